// File: rtl/regn_univ_pl.sv
// regn_univ_pl: N-bit universal shift register with parallel load and multi-cycle shift (optional parity output under REGN_UNIV_PARITY_EN)
module regn_univ_pl #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pl,
    input  logic [N-1:0]  di,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic          start,
    input  logic          sin,
    output logic [N-1:0]  do_o,
    output logic          busy,
    output logic          done
`ifdef REGN_UNIV_PARITY_EN
    ,
    output logic          par
`endif
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  do_q, do_d, step;
    logic [AW-1:0] count_q, count_d;
    logic [1:0]    mode_q, mode_d;
    assign step = mode_q == 2'b00 ? {do_q[N-2:0], sin} :
                  mode_q == 2'b01 ? {sin, do_q[N-1:1]} :
                  mode_q == 2'b10 ? {do_q[N-1], do_q[N-1:1]} :
                                    {do_q[N-2:0], do_q[N-1]};
    assign do_o = do_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    // next state: load/start only accepted in IDLE, one step per SHIFT cycle while count is nonzero
    always_comb begin
        state_d = state_q;
        do_d    = do_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (pl) begin
                    do_d = di;
                end else if (start) begin
                    mode_d  = mode;
                    count_d = amt;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    do_d    = step;
                    count_d = count_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset aborts any shift in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            do_q    <= '0;
            count_q <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            do_q    <= do_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end
`ifdef REGN_UNIV_PARITY_EN
    logic par_q;
    assign par = par_q;
    // parity tracks the value the register takes on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= ^do_d;
    end
`endif
endmodule

// File: tb/tb_regn_univ_pl.sv
// tb_regn_univ_pl: directed self-checking bench for regn_univ_pl at N=8
module tb_regn_univ_pl;
    logic       clk = 0, rst_n = 0, pl = 0, start = 0, sin = 0;
    logic [7:0] di = 0;
    logic [1:0] mode = 0;
    logic [2:0] amt = 0;
    logic [7:0] do_o;
    logic       busy, done;
    int         checks = 0, passes = 0;
`ifdef REGN_UNIV_PARITY_EN
    logic       par;
`endif

    regn_univ_pl #(.N(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .pl(pl), .di(di), .mode(mode), .amt(amt),
        .start(start), .sin(sin), .do_o(do_o), .busy(busy), .done(done)
`ifdef REGN_UNIV_PARITY_EN
        , .par(par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        pl = 1; di = v;
        tick();
        pl = 0;
    endtask

    task automatic run_shift(input string tag, input logic [1:0] m, input logic [2:0] a, input logic s, input logic [7:0] exp);
        int n;
        mode = m; amt = a; sin = s; start = 1;
        tick();
        start = 0;
        mode = ~m; amt = ~a;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, a + 2);
        check({tag, "_do"}, do_o, exp);
        check({tag, "_busy"}, busy, 1'b1);
        tick();
        check({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        #12;
        check("rst_do", do_o, 8'h00);
        check("rst_flags", {busy, done}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1;
        load(8'hA5);
        check("load_do", do_o, 8'hA5);
        check("load_flags", {busy, done}, 2'b00);

        load(8'h81);
        mode = 2'b10; amt = 3; start = 1;
        tick();
        start = 0; mode = 2'b00; amt = 7; sin = 1;
        check("asr_e1_busy", {busy, done}, 2'b10);
        for (int e = 2; e <= 4; e++) begin
            tick();
            check("asr_mid", {busy, done, do_o}, {2'b10, e == 2 ? 8'hC0 : e == 3 ? 8'hE0 : 8'hF0});
        end
        tick();
        check("asr_e5", {busy, done, do_o}, {2'b11, 8'hF0});
        tick();
        check("asr_e6", {busy, done, do_o}, {2'b00, 8'hF0});

        load(8'h81);
        run_shift("rol1", 2'b11, 1, 0, 8'h03);
        run_shift("shl2", 2'b00, 2, 1, 8'h0F);
        load(8'h81);
        run_shift("lsr2", 2'b01, 2, 1, 8'hE0);
        load(8'h5A);
        run_shift("amt0", 2'b00, 0, 1, 8'h5A);
        load(8'h96);
        run_shift("rol7", 2'b11, 7, 0, 8'h4B);
        run_shift("rol1b", 2'b11, 1, 0, 8'h96);

        pl = 1; start = 1; di = 8'h3C; mode = 2'b00; amt = 2;
        tick();
        pl = 0; start = 0;
        check("pl_start_do", do_o, 8'h3C);
        check("pl_start_busy", busy, 1'b0);
        tick();
        check("pl_start_after", {busy, done, do_o}, {2'b00, 8'h3C});

        load(8'h81);
        mode = 2'b00; amt = 6; sin = 0; start = 1;
        tick();
        start = 0; pl = 1; di = 8'hFF;
        tick();
        check("busy_pl_ign", do_o, 8'h02);
        rst_n = 0;
        #1;
        check("mid_rst_do", do_o, 8'h00);
        check("mid_rst_flags", {busy, done}, 2'b00);
        #2 rst_n = 1; pl = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_done_after_rst", {busy, done}, 2'b00);
        end
        load(8'h11);
        check("post_rst_load", do_o, 8'h11);

`ifdef REGN_UNIV_PARITY_EN
        load(8'h07);
        check("par_07", par, 1'b1);
        load(8'h03);
        check("par_03", par, 1'b0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
